// File: rtl/spi_slave_pkg.sv
// Shared types for the SPI slave: FSM states, SPI mode encoding and the bit-counter width helper.
// Pure declarations; no logic, no latency, no flow control.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

    // Standard SPI mode numbering: bit 1 is CPOL, bit 0 is CPHA.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    function automatic spi_mode_t mode_of(input logic cpol, input logic cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

    function automatic int bit_cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// Synchronous word FIFO with full/empty flags; head word is visible combinationally on o_dat.
// Latency: a push is readable 1 clk later. Backpressure: push at full is accepted only with a same-cycle pop.
module spi_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave (modes 0-3, multi-word frames) bridging the SPI pins to TX/RX ready/valid FIFOs.
// Latency: sclk pin edge acted on SYNC_STAGES+1 clk later; rx_valid rises 1 clk after slave_done. Backpressure: tx_ready = TX not full; a word arriving at a full RX FIFO is dropped and flagged.
// Build option SPI_SLAVE_LSB_FIRST_EN adds a lsb_first port, latched at CS fall, selecting LSB-first shifting.
module spi_slave_stream
    import spi_slave_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              CS,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              slave_done,
    output logic              tx_underrun,
    output logic              rx_overrun,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              err_clr
);

    localparam int                CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    spi_state_t             r_state;
    spi_mode_t              r_mode;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_rx;
    logic [DATA_W-1:0]      r_rx_word;
    logic                   r_miso;
    logic                   r_done;
    logic                   r_underrun;
    logic                   r_overrun;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    logic                   r_lsb;
`endif

    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_s;
    logic [1:0]             w_mode_b;
    logic                   w_cpol;
    logic                   w_cpha;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_shift_ev;
    logic                   w_in_load;
    logic                   w_tx_pop;
    logic                   w_rx_pop;
    logic                   w_tx_full;
    logic                   w_tx_empty;
    logic                   w_rx_full;
    logic                   w_rx_empty;
    logic [DATA_W-1:0]      w_tx_head;
    logic [DATA_W-1:0]      w_rx_head;
    logic [DATA_W-1:0]      w_load_word;
    logic                   w_load_bit;
    logic [DATA_W-1:0]      w_load_rest;
    logic                   w_out_bit;
    logic [DATA_W-1:0]      w_out_rest;
    logic [DATA_W-1:0]      w_rx_next;

    // CS chain resets to "asserted" so a CS already low at reset release is not taken as a fresh fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s   = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];

    assign w_mode_b   = r_mode;
    assign w_cpol     = w_mode_b[1];
    assign w_cpha     = w_mode_b[0];
    assign w_rise     = w_sclk_s & ~r_sclk_d;
    assign w_fall     = ~w_sclk_s & r_sclk_d;
    assign w_lead     = w_cpol ? w_fall : w_rise;
    assign w_trail    = w_cpol ? w_rise : w_fall;
    assign w_sample   = w_cpha ? w_trail : w_lead;
    assign w_shift_ev = w_cpha ? w_lead : w_trail;

    assign w_in_load  = (r_state == LOAD) && !w_cs_s;
    assign w_tx_pop   = w_in_load && !w_tx_empty;
    assign w_rx_pop   = rx_ready && !w_rx_empty;

    always_comb begin
        w_load_word = w_tx_empty ? '0 : w_tx_head;
        w_load_bit  = w_load_word[DATA_W-1];
        w_load_rest = {w_load_word[DATA_W-2:0], 1'b0};
        w_out_bit   = r_shift[DATA_W-1];
        w_out_rest  = {r_shift[DATA_W-2:0], 1'b0};
        w_rx_next   = {r_rx[DATA_W-2:0], w_mosi_s};
`ifdef SPI_SLAVE_LSB_FIRST_EN
        if (r_lsb) begin
            w_load_bit  = w_load_word[0];
            w_load_rest = {1'b0, w_load_word[DATA_W-1:1]};
            w_out_bit   = r_shift[0];
            w_out_rest  = {1'b0, r_shift[DATA_W-1:1]};
            w_rx_next   = {w_mosi_s, r_rx[DATA_W-1:1]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mode    <= MODE0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rx      <= '0;
            r_rx_word <= '0;
            r_miso    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            r_lsb     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_cs_s) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (r_cs_d) begin
                            r_mode    <= mode_of(CPOL, CPHA);
`ifdef SPI_SLAVE_LSB_FIRST_EN
                            r_lsb     <= lsb_first;
`endif
                            r_bit_cnt <= '0;
                            r_state   <= LOAD;
                        end
                    end
                    LOAD: begin
                        // CPHA=0 must have the first bit on the pin before the first leading edge.
                        if (w_cpha) begin
                            r_shift <= w_load_word;
                        end else begin
                            r_shift <= w_load_rest;
                            r_miso  <= w_load_bit;
                        end
                        r_state <= SHIFT;
                    end
                    SHIFT: begin
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_rx_word <= w_rx_next;
                                r_done    <= 1'b1;
                                if (w_cpha) begin
                                    r_state <= LOAD;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                            end
                        end
                        if (w_shift_ev) begin
                            // A trailing edge seen with the counter wrapped closes a CPHA=0 word.
                            if (!w_cpha && (r_bit_cnt == '0)) begin
                                r_state <= LOAD;
                            end else begin
                                r_miso  <= w_out_bit;
                                r_shift <= w_out_rest;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_in_load && w_tx_empty) begin
                r_underrun <= 1'b1;
            end
            if (r_done && w_rx_full && !w_rx_pop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    spi_word_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (tx_valid && !w_tx_full),
        .i_dat   (tx_data),
        .i_pop   (w_tx_pop),
        .o_dat   (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    spi_word_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_done),
        .i_dat   (r_rx_word),
        .i_pop   (rx_ready),
        .o_dat   (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign MISO        = r_miso && !w_cs_s;
    assign tx_ready    = !w_tx_full;
    assign rx_data     = w_rx_head;
    assign rx_valid    = !w_rx_empty;
    assign slave_done  = r_done;
    assign tx_underrun = r_underrun;
    assign rx_overrun  = r_overrun;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: bit-banged SPI master, hand-computed expected words and flags.
module tb_spi_slave_stream;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       CS;
    logic       MOSI;
    logic       MISO;
    logic       CPOL;
    logic       CPHA;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       slave_done;
    logic       tx_underrun;
    logic       rx_overrun;
    logic       err_clr;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         d0;
    logic [7:0] mtx [8];
    logic [7:0] srx [8];
    logic [7:0] s_tmp;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (slave_done) done_cnt <= done_cnt + 1;
    end

    spi_slave_stream #(
        .DATA_W      (8),
        .TX_DEPTH    (4),
        .RX_DEPTH    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .CS          (CS),
        .MOSI        (MOSI),
        .MISO        (MISO),
        .CPOL        (CPOL),
        .CPHA        (CPHA),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .slave_done  (slave_done),
        .tx_underrun (tx_underrun),
        .rx_overrun  (rx_overrun),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 200) begin
            clks(1);
            t++;
        end
        if (!tx_ready) check("push_timeout", {31'd0, tx_ready}, 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        clks(1);
        tx_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        int t = 0;
        while (!rx_valid && t < 200) begin
            clks(1);
            t++;
        end
        check({tag, "_vld"}, {31'd0, rx_valid}, 32'd1);
        check(tag, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        clks(1);
        rx_ready = 1'b0;
    endtask

    task automatic err_pulse();
        err_clr = 1'b1;
        clks(1);
        err_clr = 1'b0;
        clks(1);
    endtask

    task automatic xfer_word(input bit cpol, input bit cpha, input logic [7:0] m,
                             input int nbits, output logic [7:0] s);
        s = '0;
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) begin
                MOSI = m[7-k];
                clks(HALF);
                s[7-k] = MISO;
                sclk = ~cpol;
                clks(HALF);
                sclk = cpol;
            end else begin
                clks(HALF);
                sclk = ~cpol;
                MOSI = m[7-k];
                clks(HALF);
                s[7-k] = MISO;
                sclk = cpol;
            end
        end
    endtask

    task automatic frame(input bit cpol, input bit cpha, input int nw, input int nbits);
        logic [7:0] s;
        CPOL = cpol;
        CPHA = cpha;
        sclk = cpol;
        MOSI = 1'b0;
        clks(10);
        CS = 1'b0;
        clks(10);
        for (int w = 0; w < nw; w++) begin
            xfer_word(cpol, cpha, mtx[w], nbits, s);
            srx[w] = s;
        end
        clks(HALF);
        CS = 1'b1;
        clks(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; CS = 1'b1; MOSI = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        clks(4);
        rst = 1'b0;
        clks(1);

        check("rst_miso",     {31'd0, MISO},        32'd0);
        check("rst_tx_ready", {31'd0, tx_ready},    32'd1);
        check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("rst_rx_data",  {24'd0, rx_data},     32'd0);
        check("rst_done",     {31'd0, slave_done},  32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_overrun",  {31'd0, rx_overrun},  32'd0);

        // Mode 0 single byte
        push_tx(8'hA5);
        mtx[0] = 8'h3C;
        d0 = done_cnt;
        frame(1'b0, 1'b0, 1, 8);
        check("m0_miso", {24'd0, srx[0]}, 32'hA5);
        check("m0_done", done_cnt - d0, 32'd1);
        pop_check("m0_rx", 8'h3C);
        check("m0_rx_empty", {31'd0, rx_valid}, 32'd0);

        // Modes 1..3
        for (int md = 1; md < 4; md++) begin
            push_tx(8'h7E);
            mtx[0] = 8'h81;
            frame(md[1], md[0], 1, 8);
            check($sformatf("m%0d_miso", md), {24'd0, srx[0]}, 32'h7E);
            pop_check($sformatf("m%0d_rx", md), 8'h81);
        end

        // Three-word frame
        push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
        mtx[0] = 8'hAA; mtx[1] = 8'hBB; mtx[2] = 8'hCC;
        d0 = done_cnt;
        frame(1'b0, 1'b0, 3, 8);
        check("multi_miso0", {24'd0, srx[0]}, 32'h11);
        check("multi_miso1", {24'd0, srx[1]}, 32'h22);
        check("multi_miso2", {24'd0, srx[2]}, 32'h33);
        check("multi_done", done_cnt - d0, 32'd3);
        pop_check("multi_rx0", 8'hAA);
        pop_check("multi_rx1", 8'hBB);
        pop_check("multi_rx2", 8'hCC);

        // Underrun with empty TX FIFO
        err_pulse();
        check("ur_cleared_before", {31'd0, tx_underrun}, 32'd0);
        mtx[0] = 8'h96;
        frame(1'b0, 1'b0, 1, 8);
        check("ur_miso", {24'd0, srx[0]}, 32'h00);
        check("ur_flag", {31'd0, tx_underrun}, 32'd1);
        pop_check("ur_rx", 8'h96);
        err_pulse();
        check("ur_clr", {31'd0, tx_underrun}, 32'd0);

        // Overrun: 5 words into a 4-deep RX FIFO
        err_pulse();
        for (int i = 0; i < 5; i++) mtx[i] = 8'(i + 1);
        d0 = done_cnt;
        frame(1'b0, 1'b0, 5, 8);
        check("ov_flag", {31'd0, rx_overrun}, 32'd1);
        check("ov_done", done_cnt - d0, 32'd5);
        pop_check("ov_rx0", 8'h01);
        pop_check("ov_rx1", 8'h02);
        pop_check("ov_rx2", 8'h03);
        pop_check("ov_rx3", 8'h04);
        check("ov_rx_empty", {31'd0, rx_valid}, 32'd0);

        // TX full, then a 4-word mode 3 frame drains it
        err_pulse();
        push_tx(8'hF1); push_tx(8'hF2); push_tx(8'hF3); push_tx(8'hF4);
        check("txfull_ready", {31'd0, tx_ready}, 32'd0);
        mtx[0] = 8'h10; mtx[1] = 8'h11; mtx[2] = 8'h12; mtx[3] = 8'h13;
        frame(1'b1, 1'b1, 4, 8);
        check("txfull_miso0", {24'd0, srx[0]}, 32'hF1);
        check("txfull_miso3", {24'd0, srx[3]}, 32'hF4);
        check("txfull_no_ov", {31'd0, rx_overrun}, 32'd0);
        pop_check("txfull_rx0", 8'h10);
        pop_check("txfull_rx1", 8'h11);
        pop_check("txfull_rx2", 8'h12);
        pop_check("txfull_rx3", 8'h13);

        // CS raised after 5 bits
        mtx[0] = 8'hFF;
        d0 = done_cnt;
        frame(1'b0, 1'b0, 1, 5);
        check("part_done", done_cnt - d0, 32'd0);
        check("part_rx_valid", {31'd0, rx_valid}, 32'd0);
        push_tx(8'hC3);
        mtx[0] = 8'h5A;
        d0 = done_cnt;
        frame(1'b0, 1'b0, 1, 8);
        check("part_next_miso", {24'd0, srx[0]}, 32'hC3);
        check("part_next_done", done_cnt - d0, 32'd1);
        pop_check("part_next_rx", 8'h5A);

        // Reset mid-frame with CS held low: slave must ignore the rest of this frame
        push_tx(8'h77); push_tx(8'h66);
        CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0;
        clks(10);
        CS = 1'b0;
        clks(10);
        xfer_word(1'b0, 1'b0, 8'hFF, 3, s_tmp);
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        clks(1);
        check("mrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        d0 = done_cnt;
        xfer_word(1'b0, 1'b0, 8'hFF, 8, s_tmp);
        check("mrst_done", done_cnt - d0, 32'd0);
        check("mrst_no_rx", {31'd0, rx_valid}, 32'd0);
        check("mrst_miso", {24'd0, s_tmp}, 32'h00);
        clks(HALF);
        CS = 1'b1;
        clks(20);
        push_tx(8'h3C);
        mtx[0] = 8'h0F;
        frame(1'b0, 1'b0, 1, 8);
        check("mrst_next_miso", {24'd0, srx[0]}, 32'h3C);
        pop_check("mrst_next_rx", 8'h0F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_stream.md
# spi_slave_stream

Parametrised SPI slave that moves DATA_W-bit words between an SPI bus and the system clock domain through a TX FIFO and an RX FIFO. It supports all four CPOL/CPHA modes and back-to-back multi-word frames inside one CS assertion, and reports underrun and overrun conditions. It replaces single-byte, single-shot slave use in the SPI subsystem: the system side sees ready/valid streams instead of a one-word Tx/Rx pair.

## Interface
- DATA_W, 8: word width in bits, ≥ 4.
- TX_DEPTH, 4: TX FIFO entries, power of two, ≥ 2.
- RX_DEPTH, 4: RX FIFO entries, power of two, ≥ 2.
- SYNC_STAGES, 2: synchroniser flops on sclk, MOSI and CS, ≥ 2.

- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- CS  in  1  chip select, active low, asynchronous.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out.
- CPOL  in  1  idle level of sclk.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- tx_data  in  DATA_W  word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX FIFO not full.
- rx_data  out  DATA_W  received word at the RX FIFO head.
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  pop the RX head.
- slave_done  out  1  one-clk pulse per completed word.
- tx_underrun  out  1  sticky: a word was started with the TX FIFO empty.
- rx_overrun  out  1  sticky: a received word was dropped because the RX FIFO was full.
- err_clr  in  1  clears both sticky flags.

## Operation
- sclk, MOSI and CS each pass through SYNC_STAGES flops. Edges are detected on the synchronised sclk.
- Leading edge is the sclk transition away from CPOL; trailing edge is the transition back to CPOL.
- CPOL and CPHA are latched at CS assertion and held for the whole frame.
- States:
  - IDLE: waits for CS falling.
  - LOAD: pops the TX FIFO head into the shift register. If the TX FIFO is empty, it loads all zeros and sets tx_underrun. Goes to SHIFT.
  - SHIFT: counts bits, bit_cnt from 0 to DATA_W-1.
- Shift timing:
  - CPHA=0: the first bit is on MISO at the end of LOAD. MOSI is sampled on leading edges; MISO shifts on trailing edges.
  - CPHA=1: MISO shifts on leading edges; MOSI is sampled on trailing edges.
- Word completion, on the DATA_W-th sample:
  - The RX word is pushed to the RX FIFO. If the RX FIFO is full, the word is dropped and rx_overrun is set.
  - slave_done pulses.
  - bit_cnt wraps to 0 and the block re-enters LOAD for the next word. For CPHA=0 the reload happens on the following trailing edge.
- Bit order is MSB first unless the Configuration macro is enabled.
- CS rising in any state returns the block to IDLE:
  - A partial RX word is discarded: no push and no slave_done.
  - A popped partial TX word is lost and is not re-queued.
- MISO is 0 whenever synchronised CS is high.
- FIFO rules:
  - Push on tx_valid && tx_ready; pop on rx_valid && rx_ready.
  - A simultaneous push and pop on the same FIFO leaves its level unchanged.
  - A pop and push at RX_DEPTH-full in the same cycle accepts the push.
- err_clr takes priority over a same-cycle set of either sticky flag.

## Timing
- Reset values: MISO=0, tx_ready=1, rx_valid=0, rx_data=0, slave_done=0, tx_underrun=0, rx_overrun=0, state IDLE, both FIFOs empty.
- A pin edge on sclk is acted on SYNC_STAGES+1 clk cycles later.
- MISO changes 1 clk after the internal shift event.
- rx_valid rises 1 clk after the push. slave_done is asserted in the same cycle as the push.
- sclk frequency must be ≤ clk/(2·(SYNC_STAGES+2)). Faster sclk is unsupported.
- A tx push is visible to LOAD on the next clk.
- rst mid-frame: all state and FIFOs clear next clk. The block then waits for a fresh CS falling edge, even if CS is already low.

## Configuration
- SPI_SLAVE_LSB_FIRST_EN:
  - Defined: adds input port lsb_first (1 bit), latched at CS assertion with CPOL/CPHA. When 1, the LSB is shifted first in both directions.
  - Undefined: the port is absent and operation is MSB first only.

## Structure
- Package spi_slave_pkg holds the FSM state enum (IDLE, LOAD, SHIFT), the mode encoding derived from CPOL/CPHA, and a helper for the bit-counter width, $clog2(DATA_W).
- One sub-module, spi_word_fifo: synchronous FIFO parametrised on width and depth, with full/empty flags. It is instantiated twice, once for TX and once for RX.

## Test plan
- Mode 0, DATA_W=8, TX preloaded with 0xA5, master sends 0x3C → MISO carries 0xA5, rx_data=0x3C, one slave_done pulse.
- Modes 1, 2 and 3, each with master byte 0x81 and TX word 0x7E → bytes exchange correctly in each mode.
- One CS frame of 3 words with TX {0x11, 0x22, 0x33} and master {0xAA, 0xBB, 0xCC} → RX FIFO holds the master words in order and slave_done pulses 3 times.
- TX FIFO empty at CS fall → MISO all zeros, tx_underrun=1; err_clr → tx_underrun=0.
- RX_DEPTH=4 with no pops and 5 words sent → the first 4 are kept, rx_overrun=1.
- CS raised after 5 bits → no RX push and no slave_done; the next frame receives 0x5A correctly.
